sd_spi_ctrl: RTL

SD_SPI_CTRL -- requirements
Module: sd_spi_ctrl

---
 rtl/sd_spi_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sd_spi_ctrl.sv
// SPI-mode SD card byte engine with a small register window (DATA, CTRL/STATUS, DIV).
// Mode 0, MSB first; the clock divider sets the length of each half-period of sclk.
module sd_spi_ctrl #(
    parameter logic [7:0] DEFAULT_DIV = 8'd124
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic [3:0]  wenable,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        sclk,
    output logic        cs,
    output logic        mosi,
    input  logic        miso,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOW  = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;

    logic [1:0] state_q,   state_d;
    logic [7:0] div_q,     div_d;
    logic [7:0] div_cnt_q, div_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] tx_q,      tx_d;
    logic [7:0] rx_sh_q,   rx_sh_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       done_q,    done_d;
    logic       ovr_q,     ovr_d;
    logic       cs_en_q,   cs_en_d;
    logic       sclk_q,    sclk_d;
    logic       mosi_q,    mosi_d;

    logic wr, data_wr, ctrl_wr, div_wr, busy;
    logic unused_bits;

    assign unused_bits = ^{wdata[31:8], wenable[3:1]};

    assign wr      = sel & wenable[0];
    assign data_wr = wr & (addr == 2'd0);
    assign ctrl_wr = wr & (addr == 2'd1);
    assign div_wr  = wr & (addr == 2'd2);
    assign busy    = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        done_d    = done_q;
        ovr_d     = ovr_q;
        cs_en_d   = cs_en_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;

        // W1C clears are applied first so a same-cycle hardware set wins.
        if (ctrl_wr) begin
            cs_en_d = wdata[1];
            if (wdata[2]) done_d = 1'b0;
            if (wdata[3]) ovr_d  = 1'b0;
        end
        if (div_wr && !busy) div_d = wdata[7:0];
        if (data_wr && busy) ovr_d = 1'b1;

        case (state_q)
            IDLE: begin
                sclk_d = 1'b0;
                mosi_d = 1'b1;
                if (data_wr) begin
                    tx_d      = wdata[7:0];
                    mosi_d    = wdata[7];
                    div_cnt_d = 8'd0;
                    bit_cnt_d = 3'd0;
                    state_d   = LOW;
                end
            end
            LOW: begin
                if (div_cnt_q == div_q) begin
                    sclk_d    = 1'b1;
                    rx_sh_d   = {rx_sh_q[6:0], miso};
                    div_cnt_d = 8'd0;
                    state_d   = HIGH;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            HIGH: begin
                if (div_cnt_q == div_q) begin
                    sclk_d    = 1'b0;
                    div_cnt_d = 8'd0;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d = rx_sh_q;
                        done_d    = 1'b1;
                        mosi_d    = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        tx_d      = {tx_q[6:0], 1'b0};
                        mosi_d    = tx_q[6];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        state_d   = LOW;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            default: begin
                sclk_d  = 1'b0;
                mosi_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_q     <= DEFAULT_DIV;
            div_cnt_q <= 8'd0;
            bit_cnt_q <= 3'd0;
            tx_q      <= 8'd0;
            rx_sh_q   <= 8'd0;
            rx_data_q <= 8'd0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            cs_en_q   <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            cs_en_q   <= cs_en_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
        end
    end

    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign cs        = ~cs_en_q;
    assign dbg_state = state_q;

    always_comb begin
        rdata = 32'd0;
        case (addr)
            2'd0:    rdata = {24'd0, rx_data_q};
            2'd1:    rdata = {28'd0, ovr_q, done_q, cs_en_q, busy};
            2'd2:    rdata = {24'd0, div_q};
            default: rdata = 32'd0;
        endcase
    end

endmodule
